// File: rtl/dmem_pkg.sv
// Shared types and the load-extension helper for the pipelined data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_X = 2'd3
  } mem_size_t;

  // Bit 32 of the result is the fill bit for widths beyond 32; the caller sign-extends it.
  function automatic logic [32:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input mem_size_t   size,
                                              input logic        uns);
    logic [31:0] sh;
    logic [32:0] r;
    sh = word >> {lane, 3'b000};
    case (size)
      MEM_B:   r = {{25{~uns & sh[7]}}, sh[7:0]};
      MEM_H:   r = {{17{~uns & sh[15]}}, sh[15:0]};
      MEM_W:   r = {1'b0, sh};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-writable storage array: synchronous write, combinational read, no reset.
module dmem_bank #(
  parameter int unsigned N = 32,
  parameter int unsigned R = 8
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [N/8-1:0] be_i,
  input  logic [R-1:0]   addr_i,
  input  logic [N-1:0]   wdata_i,
  output logic [N-1:0]   rdata_o
);

  logic [N-1:0] mem_q [2**R];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < N/8; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_pipelined.sv
// Data memory with valid/ready request port, access checking, lane steering and
// a READ_LAT-deep stallable response pipeline.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned R        = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err
);

  mem_size_t      size;
  logic [1:0]     lane;
  logic [R-1:0]   widx;
  logic           oor, misal, err;
  logic           advance, accept, bank_we;
  logic [N/8-1:0] be;
  logic [N-1:0]   wdata_sh, rword, ld_data;

  assign size    = mem_size_t'(req_size);
  assign lane    = req_addr[1:0];
  assign widx    = req_addr[R+1:2];
  assign advance = !rsp_valid || rsp_ready;
  assign req_ready = advance;
  assign accept  = req_valid && advance;
  assign bank_we = accept && req_we && !err;

  always_comb begin
    oor      = (req_addr >> (R + 2)) != '0;
    misal    = (size == MEM_H && lane[0]) || (size == MEM_W && lane != 2'd0);
    err      = oor || misal || (size == MEM_X);
    be       = '0;
    wdata_sh = '0;
    case (size)
      MEM_B: begin
        be[lane]  = 1'b1;
        wdata_sh  = N'(req_wdata[7:0]) << {lane, 3'b000};
      end
      MEM_H: begin
        be[lane +: 2] = 2'b11;
        wdata_sh      = N'(req_wdata[15:0]) << {lane, 3'b000};
      end
      MEM_W: begin
        be[3:0]  = 4'hF;
        wdata_sh = req_wdata;
      end
      default: ;
    endcase
    // Stores and rejected accesses both report zero data.
    ld_data = (err || req_we) ? '0
            : N'($signed(extend_load(rword[31:0], lane, size, req_unsigned)));
  end

  dmem_bank #(.N(N), .R(R)) u_bank (
    .clk    (clk),
    .we_i   (bank_we),
    .be_i   (be),
    .addr_i (widx),
    .wdata_i(wdata_sh),
    .rdata_o(rword)
  );

  for (genvar s = 0; s < READ_LAT; s++) begin : g_stage
    logic         vld_q, vld_d;
    logic         err_q, err_d;
    logic [N-1:0] rdata_q, rdata_d;

    if (s == 0) begin : g_head
      assign vld_d   = accept;
      assign err_d   = accept && err;
      assign rdata_d = accept ? ld_data : '0;
    end else begin : g_tail
      assign vld_d   = g_stage[s-1].vld_q;
      assign err_d   = g_stage[s-1].err_q;
      assign rdata_d = g_stage[s-1].rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q   <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end else if (advance) begin
        vld_q   <= vld_d;
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
    end
  end

  assign rsp_valid = g_stage[READ_LAT-1].vld_q;
  assign rsp_err   = g_stage[READ_LAT-1].err_q;
  assign rsp_rdata = g_stage[READ_LAT-1].rdata_q;

endmodule

// File: tb/tb_dmem_pipelined.sv
// Bench for dmem_pipelined: directed vector table, randomized traffic against a
// byte-array reference model, stall and reset sequences.
module tb_dmem_pipelined;

  localparam int unsigned N     = 32;
  localparam int unsigned R     = 8;
  localparam int unsigned LAT   = 2;
  localparam int unsigned BYTES = 4 * (2**R);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
  logic [1:0]    req_size = 2'd0;
  logic [N-1:0]  req_addr = '0, req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err;
  logic [N-1:0]  rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  rsp_t       exp_q[$];
  logic [7:0] mem_b [BYTES];

  always #5 clk = ~clk;

  dmem_pipelined #(.N(N), .R(R), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, little-endian access of 1/2/4 bytes.
  function automatic void model_req(input logic we, input logic [1:0] sz, input logic uns,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic er);
    int unsigned nb;
    logic [31:0] v, ones;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    er = (nb == 0) || (a >= BYTES) || ((nb != 0) && (a % nb != 0));
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int unsigned i = 0; i < nb; i++) mem_b[a + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int unsigned i = 0; i < nb; i++) v = v | (32'(mem_b[a + i]) << (8*i));
        ones = '1;
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (ones << (8*nb));
        rd = v;
      end
    end
  endfunction

  // One clock cycle, entered and left at a negedge.
  task automatic step(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic rr,
                      output logic acc);
    rsp_t e;
    logic [31:0] rd;
    logic er;
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; rsp_ready = rr;
    #1;
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response", rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    acc = v && req_ready;
    if (acc) begin
      model_req(we, sz, uns, a, wd, rd, er);
      exp_q.push_back('{rdata: rd, err: er});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b1, acc);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic acc;
    int   cyc, issued, rsp0;
    logic [31:0] a;
    logic [1:0]  sz;
    int   r;

    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err",   32'(rsp_err),   32'd0);
    chk("reset_rsp_rdata", rsp_rdata,      32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // {we, size, uns, addr, wdata, exp_rdata, exp_err}
    vecs = '{
      '{1'b1, 2'd2, 1'b0, 32'h000, 32'hCAFEF00D, 32'h00000000, 1'b0},
      '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b1, 2'd0, 1'b0, 32'h013, 32'h00000080, 32'h00000000, 1'b0},
      '{1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        32'hFFFFFF80, 1'b0},
      '{1'b0, 2'd0, 1'b1, 32'h013, 32'h0,        32'h00000080, 1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'h80ADBEEF, 1'b0},
      '{1'b0, 2'd1, 1'b0, 32'h012, 32'h0,        32'hFFFF80AD, 1'b0},
      '{1'b0, 2'd1, 1'b1, 32'h010, 32'h0,        32'h0000BEEF, 1'b0},
      '{1'b0, 2'd0, 1'b0, 32'h011, 32'h0,        32'hFFFFFFBE, 1'b0},
      '{1'b0, 2'd1, 1'b0, 32'h011, 32'h0,        32'h00000000, 1'b1},
      '{1'b1, 2'd2, 1'b0, 32'h012, 32'h12345678, 32'h00000000, 1'b1},
      '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'h80ADBEEF, 1'b0},
      '{1'b1, 2'd2, 1'b0, 32'h400, 32'h11111111, 32'h00000000, 1'b1},
      '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h00000000, 1'b1},
      '{1'b1, 2'd3, 1'b0, 32'h000, 32'h22222222, 32'h00000000, 1'b1},
      '{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0},
      '{1'b1, 2'd2, 1'b0, 32'h014, 32'h11223344, 32'h00000000, 1'b0},
      '{1'b1, 2'd1, 1'b0, 32'h016, 32'hFFFFABCD, 32'h00000000, 1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h014, 32'h0,        32'hABCD3344, 1'b0}
    };

    @(negedge clk);
    foreach (vecs[i]) begin
      req_valid = 1'b1; req_we = vecs[i].we; req_size = vecs[i].size;
      req_unsigned = vecs[i].uns; req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
      rsp_ready = 1'b1;
      #1;
      chk("vec_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      while (!rsp_valid && cyc < 10) begin
        @(posedge clk); @(negedge clk);
        cyc++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'(LAT));
      chk($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
    end
    @(posedge clk); @(negedge clk);
    chk("vec_rsp_cleared", 32'(rsp_valid), 32'd0);

    // Fill every word so random loads never see unwritten storage.
    for (int unsigned w = 0; w < 2**R; w++) step(1'b1, 1'b1, 2'd2, 1'b0, 32'(4*w), $urandom, 1'b1, acc);
    drain();

    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = $urandom_range(0, BYTES - 1);
      if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(R + 2, 31));
      step($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
           a, $urandom, $urandom_range(0, 3) != 0, acc);
    end
    drain();

    // Four back-to-back loads, consumer stalls for three cycles.
    issued = 0;
    rsp0 = n_rsp;
    for (int c = 0; c < 30 && (issued < 4 || exp_q.size() != 0); c++) begin
      step(issued < 4, 1'b0, 2'd2, 1'b0, 32'(32'h40 + 4*issued), '0, !(c >= 2 && c < 5), acc);
      if (c >= 2 && c < 5) chk("stall_req_ready", 32'(acc), 32'd0);
      if (acc) issued++;
    end
    chk("stall_issued", 32'(issued), 32'd4);
    chk("stall_rsp_count", 32'(n_rsp - rsp0), 32'd4);
    chk("stall_left", 32'(exp_q.size()), 32'd0);

    // Reset with two loads in flight; storage must survive.
    step(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h5A5A1234, 1'b1, acc);
    drain();
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, '0, 1'b1, acc);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h24, '0, 1'b1, acc);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    exp_q.delete();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h20; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 10) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk("post_rst_latency", 32'(cyc), 32'(LAT));
    chk("post_rst_rdata", rsp_rdata, 32'h5A5A1234);
    chk("post_rst_err", 32'(rsp_err), 32'd0);
    @(posedge clk); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
